// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_bit_slice
// Purpose  : Parameterised ripple ALU slice with OR / AND / ADD and a fourth
//            operation chosen at build time. Combinational result/cout feed
//            the datapath directly; a registered copy plus a zero flag feed
//            the next pipeline stage. WIDTH=1 is the single-bit slice that
//            is cascaded through cin/cout in the CPU datapath.
//
// Build macro:
//   ALU_SUB_EN  defined   -> op 2'b11 = subtract-with-carry (a + ~b + cin)
//               undefined -> op 2'b11 = XOR (a ^ b), cout = 0
//
// Ports:
//   clk       in   1      clock (registered outputs only)
//   rst_n     in   1      asynchronous active-low reset
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   cin       in   1      carry-in, used by arithmetic ops only
//   op        in   2      00 OR, 01 AND, 10 ADD, 11 SUB/XOR
//   result    out  WIDTH  combinational result
//   cout      out  1      combinational carry-out
//   result_q  out  WIDTH  registered result
//   cout_q    out  1      registered carry-out
//   zero_q    out  1      registered (result == 0)
//
// Revision : 1.0  initial release
// ============================================================================
module alu_bit_slice #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [WIDTH-1:0] result_q,
    output logic             cout_q,
    output logic             zero_q
);

    localparam logic [1:0] c_OP_OR  = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_ALT = 2'b11;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // A single adder serves both ADD and SUB; subtraction just inverts b.
    // The caller supplies cin=1 to complete the two's-complement negate,
    // which lets cin chain across slices as an inverted borrow.
`ifdef ALU_SUB_EN
    assign w_b_eff = (op == c_OP_ALT) ? ~b : b;
`else
    assign w_b_eff = b;
`endif

    assign w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (op)
            c_OP_OR:  result = a | b;
            c_OP_AND: result = a & b;
            c_OP_ADD: {cout, result} = w_sum;
`ifdef ALU_SUB_EN
            c_OP_ALT: {cout, result} = w_sum;
`else
            c_OP_ALT: result = a ^ b;
`endif
            default: begin
                result = '0;
                cout   = 1'b0;
            end
        endcase
    end

    // Reset value of zero_q is 1 so it stays consistent with result_q = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            cout_q   <= cout;
            zero_q   <= (result == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bit_slice
// Purpose  : Self-checking bench for alu_bit_slice. Instantiates a 1-bit and
//            a 4-bit slice; combinational outputs are checked directly,
//            registered outputs through an expected-value queue. Honours the
//            ALU_SUB_EN build macro for op 2'b11.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_bit_slice;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] op = 2'b00;
    logic       cin = 1'b0;

    logic [0:0] a1 = '0, b1 = '0, r1, r1_q;
    logic       c1, c1_q, z1_q;
    logic [3:0] a4 = '0, b4 = '0, r4, r4_q;
    logic       c4, c4_q, z4_q;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      tag;
        bit         wide;
        logic [3:0] r;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sb[$];

    alu_bit_slice #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin), .op(op),
        .result(r1), .cout(c1), .result_q(r1_q), .cout_q(c1_q), .zero_q(z1_q)
    );

    alu_bit_slice #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .op(op),
        .result(r4), .cout(c4), .result_q(r4_q), .cout_q(c4_q), .zero_q(z4_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour: returns {cout, result[3:0]} for a w-bit slice.
    function automatic logic [4:0] model(input logic [1:0] o, input logic [3:0] x,
                                         input logic [3:0] y, input logic ci, input int w);
        logic [4:0] mask;
        logic [4:0] s;
        logic [4:0] out;
        mask = 5'((1 << w) - 1);
        out  = '0;
        case (o)
            2'b00: out = {1'b0, (x | y) & mask[3:0]};
            2'b01: out = {1'b0, (x & y) & mask[3:0]};
            2'b10: begin
                s   = 5'(x) + 5'(y) + 5'(ci);
                out = {s[w], s[3:0] & mask[3:0]};
            end
            default: begin
`ifdef ALU_SUB_EN
                s   = 5'(x) + 5'(~y & mask[3:0]) + 5'(ci);
                out = {s[w], s[3:0] & mask[3:0]};
`else
                out = {1'b0, (x ^ y) & mask[3:0]};
`endif
            end
        endcase
        return out;
    endfunction

    task automatic push_exp(input string tag, input bit wide, input logic [4:0] m);
        exp_t e;
        e.tag  = tag;
        e.wide = wide;
        e.r    = m[3:0];
        e.c    = m[4];
        e.z    = (m[3:0] == 4'd0);
        sb.push_back(e);
    endtask

    // Drive both slices before a posedge, then compare registered outputs after it.
    task automatic reg_step(input string tag, input logic [1:0] o, input logic ci,
                            input logic x1, input logic y1,
                            input logic [3:0] x4, input logic [3:0] y4);
        exp_t e;
        op  = o;
        cin = ci;
        a1  = x1;
        b1  = y1;
        a4  = x4;
        b4  = y4;
        push_exp({tag, "_w1"}, 1'b0, model(o, {3'b0, x1}, {3'b0, y1}, ci, 1));
        push_exp({tag, "_w4"}, 1'b1, model(o, x4, y4, ci, 4));
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.wide) begin
                check({e.tag, "_rq"}, {4'b0, r4_q}, {4'b0, e.r});
                check({e.tag, "_cq"}, {7'b0, c4_q}, {7'b0, e.c});
                check({e.tag, "_zq"}, {7'b0, z4_q}, {7'b0, e.z});
            end else begin
                check({e.tag, "_rq"}, {7'b0, r1_q}, {4'b0, e.r});
                check({e.tag, "_cq"}, {7'b0, c1_q}, {7'b0, e.c});
                check({e.tag, "_zq"}, {7'b0, z1_q}, {7'b0, e.z});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_rq1", {7'b0, r1_q}, 8'h00);
        check("rst_cq1", {7'b0, c1_q}, 8'h00);
        check("rst_zq1", {7'b0, z1_q}, 8'h01);
        check("rst_rq4", {4'b0, r4_q}, 8'h00);
        check("rst_zq4", {7'b0, z4_q}, 8'h01);

        // Combinational checks run while reset is held: reset must not affect them.
        op = 2'b00; a1 = 1'b0; b1 = 1'b0; cin = 1'b0; #1;
        check("or00_r", {7'b0, r1}, 8'h00);
        check("or00_c", {7'b0, c1}, 8'h00);
        a1 = 1'b1; #1;
        check("or10_r", {7'b0, r1}, 8'h01);
        b1 = 1'b1; cin = 1'b1; #1;
        check("or11_r", {7'b0, r1}, 8'h01);
        check("or11_c", {7'b0, c1}, 8'h00);

        op = 2'b01; a1 = 1'b1; b1 = 1'b0; #1;
        check("and10_r", {7'b0, r1}, 8'h00);
        check("and10_c", {7'b0, c1}, 8'h00);
        b1 = 1'b1; #1;
        check("and11_r", {7'b0, r1}, 8'h01);
        check("and11_c", {7'b0, c1}, 8'h00);

        op = 2'b10; a1 = 1'b1; b1 = 1'b1; cin = 1'b0; #1;
        check("add110", {6'b0, c1, r1}, 8'h02);
        cin = 1'b1; #1;
        check("add111", {6'b0, c1, r1}, 8'h03);
        a1 = 1'b0; b1 = 1'b0; #1;
        check("add001", {6'b0, c1, r1}, 8'h01);

        a4 = 4'hF; b4 = 4'h1; cin = 1'b0; #1;
        check("add4_wrap", {3'b0, c4, r4}, 8'h10);
        op = 2'b00; a4 = 4'hA; b4 = 4'h5; #1;
        check("or4", {3'b0, c4, r4}, 8'h0F);

        op = 2'b11; a4 = 4'd5; b4 = 4'd3; cin = 1'b1; #1;
`ifdef ALU_SUB_EN
        check("sub53", {3'b0, c4, r4}, 8'h12);
        a4 = 4'd3; b4 = 4'd5; #1;
        check("sub35", {3'b0, c4, r4}, 8'h0E);
`else
        check("xor53", {3'b0, c4, r4}, 8'h06);
        a4 = 4'd3; b4 = 4'd5; cin = 1'b0; #1;
        check("xor35", {3'b0, c4, r4}, 8'h06);
`endif
        check("rst_held_zq1", {7'b0, z1_q}, 8'h01);

        // Registered path: release reset on a negedge, then one capture per edge.
        @(negedge clk);
        rst_n = 1'b1;
        reg_step("reg_add11", 2'b10, 1'b0, 1'b1, 1'b1, 4'd7, 4'd9);
        reg_step("reg_add10", 2'b10, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3);

        // Asynchronous reset between edges, with result_q = 1 on the 1-bit slice.
        #1 rst_n = 1'b0;
        #1;
        check("arst_rq1", {7'b0, r1_q}, 8'h00);
        check("arst_zq1", {7'b0, z1_q}, 8'h01);
        check("arst_rq4", {4'b0, r4_q}, 8'h00);
        rst_n = 1'b1;

        reg_step("reg_alt55", 2'b11, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5);
        reg_step("reg_alt35", 2'b11, 1'b1, 1'b1, 1'b1, 4'd3, 4'd5);
        reg_step("reg_and", 2'b01, 1'b1, 1'b1, 1'b1, 4'hC, 4'h6);
        reg_step("reg_or0", 2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
